fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage at the head of the processor pipeline. Owns the program counter, issues one instruction-memory request at a time, and presents a packed {valid, pc, instr} fetch packet to the IF/ID pipeline register. It honours the hazard unit's stall and the execute stage's branch redirect, squashing wrong-path fetches without losing or duplicating instructions.

## Interface
- ADDR_W, 32, PC and memory address width
- INSTR_W, 32, instruction width
- RESET_PC, 0, PC value loaded on reset
- PC_STEP, 4, PC increment per fetched instruction
- clk  input  1  clock; all state updates on posedge
- reset  input  1  asynchronous, active-low reset
- stall  input  1  IF/ID register not enabled this cycle; fetch_packet must hold
- branch_taken  input  1  redirect request from execute stage
- branch_target  input  ADDR_W  redirect address, used verbatim
- imem_req  output  1  memory request valid
- imem_addr  output  ADDR_W  request address (equals pc register)
- imem_gnt  input  1  request accepted this cycle
- imem_rvalid  input  1  response data valid (earliest: cycle after grant)
- imem_rdata  input  INSTR_W  response instruction
- fetch_packet  output  1+ADDR_W+INSTR_W  {valid, pc, instr}, MSB = valid; feeds IF/ID register
- busy  output  1  a request is outstanding (state WAIT)

## Operation
- Registers: pc, pc_req (address of outstanding request), buf (held instruction), squash flag, fetch_packet, state.
- States: FETCH, WAIT, HOLD. Reset: state=FETCH, pc=RESET_PC, pc_req=0, buf=0, squash=0, fetch_packet=0. imem_req=0 and busy=0 while reset asserted.
- FETCH: imem_req=1, imem_addr=pc. On imem_gnt: pc_req<=pc, pc<=pc+PC_STEP (modulo 2^ADDR_W), go WAIT. No grant: stay, keep requesting same address.
- WAIT: imem_req=0, busy=1. On imem_rvalid: squash set -> discard, clear squash, go FETCH; else !stall -> fetch_packet<={1,pc_req,imem_rdata}, go FETCH; else stall -> buf<=imem_rdata, go HOLD.
- HOLD: imem_req=0. !stall -> fetch_packet<={1,pc_req,buf}, go FETCH.
- Bubble rule: in any non-stall cycle with no instruction delivered, fetch_packet valid<=0 (pc/instr fields may hold). In stall cycles fetch_packet holds unchanged.
- Redirect (branch_taken=1) overrides everything in that cycle:
  - pc<=branch_target; fetch_packet valid<=0 even if stall=1.
  - FETCH with imem_gnt same cycle: go WAIT, squash<=1.
  - FETCH without grant: stay FETCH, next request uses branch_target.
  - WAIT with imem_rvalid same cycle: discard response, go FETCH, squash<=0.
  - WAIT without rvalid: squash<=1, stay WAIT.
  - HOLD: discard buf, go FETCH.
- At most one outstanding request; imem_rvalid outside WAIT is ignored.

## Timing
- imem_req/imem_addr derived from state and pc registers; stable through the cycle.
- fetch_packet is registered on posedge, stable for the IF/ID register's next posedge capture.
- Best-case latency: grant at edge N, rvalid in cycle N+1, packet valid after edge N+1; throughput one instruction per 2 cycles with zero-wait memory.
- Redirect penalty: packet valid drops after the redirect edge; first target instruction appears no earlier than 2 edges later (3 if a wrong-path response is still pending).
- Reset mid-request: all state cleared asynchronously; a late imem_rvalid after release is ignored (state FETCH).

## Test plan
- Reset then zero-wait memory (gnt=1, rvalid next cycle, rdata=addr^0xA5A5A5A5): packets pc=0,4,8 in order, valid every second cycle, bubbles between.
- stall=1 while in WAIT and rvalid arrives for pc=0x8: state HOLD, packet keeps previous value; stall released -> packet {1,0x8,buf} for exactly one capture, next request addr 0xC.
- branch_taken with target 0x100 while WAIT (no rvalid): following response for 0x4 discarded, next imem_addr=0x100, packet pc=0x100 delivered.
- branch_taken with stall=1 and valid packet: packet valid=0 after the edge; redirect and rvalid in the same WAIT cycle -> response dropped, squash stays 0.
- imem_gnt held low 3 cycles at pc=0x10: imem_req stays 1, imem_addr stays 0x10, pc unchanged; PC wrap with RESET_PC=0xFFFFFFFC: second request addr 0x0.
- Assert reset in WAIT with squash=1: all outputs zero immediately; after release first request addr=RESET_PC, stray rvalid ignored.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps one imem request in flight
// and drives the {valid, pc, instr} packet into the IF/ID register.
module fetch_stage #(
   parameter int                ADDR_W   = 32,
   parameter int                INSTR_W  = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                PC_STEP  = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      stall,
   input  logic                      branch_taken,
   input  logic [ADDR_W-1:0]         branch_target,
   output logic                      imem_req,
   output logic [ADDR_W-1:0]         imem_addr,
   input  logic                      imem_gnt,
   input  logic                      imem_rvalid,
   input  logic [INSTR_W-1:0]        imem_rdata,
   output logic [ADDR_W+INSTR_W:0]   fetch_packet,
   output logic                      busy
);

   typedef enum logic [1:0] {
      S_FETCH,
      S_WAIT,
      S_HOLD
   } state_t;

   state_t               state;
   logic [ADDR_W-1:0]    pc;
   logic [ADDR_W-1:0]    pc_req;
   logic [INSTR_W-1:0]   ibuf;
   logic                 squash;
   logic                 pkt_valid;
   logic [ADDR_W-1:0]    pkt_pc;
   logic [INSTR_W-1:0]   pkt_instr;

   assign imem_req     = reset && (state == S_FETCH);
   assign busy         = reset && (state == S_WAIT);
   assign imem_addr    = pc;
   assign fetch_packet = {pkt_valid, pkt_pc, pkt_instr};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_FETCH;
         pc        <= RESET_PC;
         pc_req    <= '0;
         ibuf      <= '0;
         squash    <= 1'b0;
         pkt_valid <= 1'b0;
         pkt_pc    <= '0;
         pkt_instr <= '0;
      end else begin
         if (!stall)
            pkt_valid <= 1'b0;
         if (branch_taken) begin
            // redirect wins: kill the packet and any wrong-path fetch
            pc        <= branch_target;
            pkt_valid <= 1'b0;
            case (state)
               S_FETCH: begin
                  if (imem_gnt) begin
                     pc_req <= pc;
                     squash <= 1'b1;
                     state  <= S_WAIT;
                  end
               end
               S_WAIT: begin
                  if (imem_rvalid) begin
                     squash <= 1'b0;
                     state  <= S_FETCH;
                  end else begin
                     squash <= 1'b1;
                  end
               end
               default: state <= S_FETCH;
            endcase
         end else begin
            case (state)
               S_FETCH: begin
                  if (imem_gnt) begin
                     pc_req <= pc;
                     pc     <= pc + ADDR_W'(PC_STEP);
                     state  <= S_WAIT;
                  end
               end
               S_WAIT: begin
                  if (imem_rvalid) begin
                     if (squash) begin
                        squash <= 1'b0;
                        state  <= S_FETCH;
                     end else if (!stall) begin
                        pkt_valid <= 1'b1;
                        pkt_pc    <= pc_req;
                        pkt_instr <= imem_rdata;
                        state     <= S_FETCH;
                     end else begin
                        ibuf  <= imem_rdata;
                        state <= S_HOLD;
                     end
                  end
               end
               S_HOLD: begin
                  if (!stall) begin
                     pkt_valid <= 1'b1;
                     pkt_pc    <= pc_req;
                     pkt_instr <= ibuf;
                     state     <= S_FETCH;
                  end
               end
               default: state <= S_FETCH;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a queue-based program-order model.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, bt, gnt, rvalid;
   logic [31:0] tgt, rdata;
   logic        imem_req, busy;
   logic [31:0] imem_addr;
   logic [64:0] fetch_packet;

   logic        req2, busy2;
   logic [31:0] addr2;
   logic [64:0] pkt2;

   always #5 clk = ~clk;

   fetch_stage dut (
      .clk(clk), .reset(rst_n), .stall(stall),
      .branch_taken(bt), .branch_target(tgt),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_gnt(gnt), .imem_rvalid(rvalid), .imem_rdata(rdata),
      .fetch_packet(fetch_packet), .busy(busy)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
      .clk(clk), .reset(rst_n), .stall(1'b0),
      .branch_taken(1'b0), .branch_target(32'h0),
      .imem_req(req2), .imem_addr(addr2),
      .imem_gnt(1'b1), .imem_rvalid(1'b1), .imem_rdata(32'h1234_5678),
      .fetch_packet(pkt2), .busy(busy2)
   );

   typedef struct { logic [31:0] addr; bit live; } req_t;
   typedef struct { logic [31:0] addr; logic [31:0] instr; } hold_t;

   req_t        out_q[$];
   hold_t       held_q[$];
   logic [31:0] m_pc;
   bit          m_valid;
   logic [31:0] m_ppc, m_pinstr;

   bit          mem_pend;
   logic [31:0] mem_addr;
   int          mem_dly, max_dly;

   int npass = 0, ntot = 0;
   logic [64:0] pk[16];

   task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
      ntot++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   function automatic logic [31:0] f(input logic [31:0] a);
      return a ^ 32'hA5A5_A5A5;
   endfunction

   task automatic model_reset();
      out_q.delete(); held_q.delete();
      m_pc = 32'h0; m_valid = 0; m_ppc = 0; m_pinstr = 0;
      mem_pend = 0; mem_dly = 0;
   endtask

   task automatic deliver(input logic [31:0] a, input logic [31:0] d);
      m_valid = 1; m_ppc = a; m_pinstr = d;
   endtask

   task automatic model_step();
      bit    req;
      req_t  r;
      hold_t h;
      req = (out_q.size() == 0) && (held_q.size() == 0);
      if (mem_pend) begin
         if (rvalid) mem_pend = 0;
         else if (mem_dly > 0) mem_dly--;
      end
      if (req && gnt) begin
         mem_pend = 1; mem_addr = m_pc;
         mem_dly = $urandom_range(max_dly, 0);
      end
      if (!stall) m_valid = 0;
      if (bt) begin
         m_valid = 0;
         if (req && gnt) out_q.push_back('{m_pc, 0});
         else if (out_q.size() != 0 && rvalid) out_q.delete();
         else if (out_q.size() != 0) out_q[0].live = 0;
         held_q.delete();
         m_pc = tgt;
      end else if (req && gnt) begin
         out_q.push_back('{m_pc, 1});
         m_pc = m_pc + 32'd4;
      end else if (out_q.size() != 0 && rvalid) begin
         r = out_q.pop_front();
         if (r.live) begin
            if (!stall) deliver(r.addr, rdata);
            else held_q.push_back('{r.addr, rdata});
         end
      end else if (held_q.size() != 0 && !stall) begin
         h = held_q.pop_front();
         deliver(h.addr, h.instr);
      end
   endtask

   task automatic check_all();
      bit ereq;
      ereq = rst_n && out_q.size() == 0 && held_q.size() == 0;
      chk("imem_req", 65'(imem_req), 65'(ereq));
      chk("imem_addr", 65'(imem_addr), 65'(m_pc));
      chk("busy", 65'(busy), 65'(rst_n && out_q.size() != 0));
      chk("pkt_valid", 65'(fetch_packet[64]), 65'(m_valid));
      if (m_valid)
         chk("pkt_body", 65'(fetch_packet[63:0]), 65'({m_ppc, m_pinstr}));
   endtask

   task automatic sample();
      @(negedge clk);
      check_all();
   endtask

   task automatic drive(input bit g, input bit s, input bit b,
                        input logic [31:0] t, input bit spur);
      gnt = g; stall = s; bt = b; tgt = t;
      if (mem_pend && mem_dly == 0) begin
         rvalid = 1; rdata = f(mem_addr);
      end else begin
         rvalid = spur && !mem_pend; rdata = $urandom;
      end
   endtask

   task automatic advance(input bit g, input bit s, input bit b,
                          input logic [31:0] t, input bit spur);
      drive(g, s, b, t, spur);
      @(posedge clk);
      model_step();
   endtask

   task automatic rnd_advance();
      advance($urandom_range(2, 0) != 0, $urandom_range(3, 0) == 0,
              $urandom_range(11, 0) == 0, {20'h0, 10'($urandom), 2'b00},
              $urandom_range(7, 0) == 0);
   endtask

   initial begin
      bit found;
      rst_n = 0; stall = 0; bt = 0; gnt = 0; rvalid = 0; tgt = 0; rdata = 0;
      max_dly = 0;
      model_reset();
      repeat (3) @(negedge clk);
      check_all();
      chk("rst_pkt", fetch_packet, 65'h0);
      chk("rst_req", 65'(imem_req), 65'h0);
      chk("rst_addr2", 65'(addr2), 65'hFFFF_FFFC);
      rst_n = 1;
      drive(0, 0, 0, 0, 0);
      @(posedge clk);
      model_step();

      for (int i = 0; i < 14; i++) begin
         sample();
         pk[i] = fetch_packet;
         if (i == 0) chk("wrap_busy", 65'({busy2, addr2}), {32'h0, 1'b1, 32'h0});
         if (i == 1) begin
            chk("wrap_addr", 65'({req2, addr2}), {32'h0, 1'b1, 32'h0});
            chk("wrap_pkt", pkt2, {1'b1, 32'hFFFF_FFFC, 32'h1234_5678});
         end
         if (i >= 8 && i <= 10)
            chk("gnt_low", 65'({imem_req, imem_addr}), {32'h0, 1'b1, 32'h10});
         advance(!(i >= 8 && i <= 10), 0, 0, 0, 0);
      end
      chk("pkt0", pk[2], {1'b1, 32'h0, 32'hA5A5_A5A5});
      chk("bub0", 65'(pk[3][64]), 65'h0);
      chk("pkt4", pk[4], {1'b1, 32'h4, 32'hA5A5_A5A1});
      chk("bub1", 65'(pk[5][64]), 65'h0);
      chk("pkt8", pk[6], {1'b1, 32'h8, 32'hA5A5_A5AD});

      max_dly = 2;
      for (int i = 0; i < 3000; i++) begin
         sample();
         rnd_advance();
      end

      found = 0;
      for (int i = 0; i < 2000 && !found; i++) begin
         sample();
         if (out_q.size() == 1 && !out_q[0].live) found = 1;
         else rnd_advance();
      end
      chk("find_squash", 65'(found), 65'h1);
      drive(0, 0, 0, 0, 0);
      rvalid = 0;
      #2 rst_n = 0;
      model_reset();
      #1;
      chk("arst_out", {imem_req, busy, fetch_packet[62:0]}, 65'h0);
      chk("arst_pkt", fetch_packet, 65'h0);
      chk("arst_addr", 65'(imem_addr), 65'h0);
      @(negedge clk);
      rst_n = 1;
      drive(0, 0, 0, 0, 0);
      rvalid = 1; rdata = 32'hDEAD_BEEF;
      @(posedge clk);
      model_step();
      sample();
      chk("post_rst", 65'({busy, imem_req, imem_addr}), {31'h0, 1'b0, 1'b1, 32'h0});
      for (int i = 0; i < 500; i++) begin
         rnd_advance();
         sample();
      end

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
